// File: rtl/param_full_adder_pkg.sv
// param_full_adder_pkg
//   Shared definitions for the parameterised ripple-carry adder.
//   MAX_N      : widest operand the block is built for.
//   ripple_w_t : widest {cout, sum} result, for users that carry the full
//                MAX_N-bit result around before narrowing it.
// Width-specific result structs are declared locally in each user, because
// a package typedef cannot depend on a module parameter.
package param_full_adder_pkg;

    localparam int unsigned MAX_N = 64;

    typedef logic [MAX_N:0] ripple_w_t;

endpackage : param_full_adder_pkg

// File: rtl/param_full_adder_fa_cell.sv
// param_full_adder_fa_cell
//   One-bit full adder, one link of the carry ripple chain.
//   a_i, b_i : operand bits
//   ci_i     : carry in from the previous cell
//   s_o      : sum bit
//   co_o     : carry out to the next cell
module param_full_adder_fa_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);

    logic p;  // propagate

    assign p    = a_i ^ b_i;
    assign s_o  = p ^ ci_i;
    assign co_o = (a_i & b_i) | (ci_i & p);

endmodule : param_full_adder_fa_cell

// File: rtl/param_full_adder.sv
// param_full_adder
//   N-bit ripple-carry adder with carry-in/carry-out and one output register
//   stage qualified by a valid bit.
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   a, b      : unsigned N-bit operands
//   cin       : carry-in (weight 1)
//   in_valid  : operands are captured on this edge when high
//   sum       : registered (a + b + cin) mod 2^N
//   cout      : registered bit N of a + b + cin
//   out_valid : high for one cycle when sum/cout carry a new result
module param_full_adder
    import param_full_adder_pkg::*;
#(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         in_valid,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         out_valid
);

    typedef struct packed {
        logic         cout;
        logic [N-1:0] sum;
    } res_t;

    if (N < 1 || N > int'(MAX_N)) begin : g_bad_n
        $error("param_full_adder: N=%0d outside 1..%0d", N, MAX_N);
    end

    // Carry ripple: c[0] is the external carry-in, c[N] the carry-out.
    logic [N:0]   c;
    logic [N-1:0] s;

    assign c[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_cell
        param_full_adder_fa_cell u_cell (
            .a_i  (a[i]),
            .b_i  (b[i]),
            .ci_i (c[i]),
            .s_o  (s[i]),
            .co_o (c[i+1])
        );
    end

    res_t res_d, res_q;
    logic vld_q;

    // Registers only load when in_valid is high, so X on idle operands
    // never reaches the outputs.
    always_comb begin
        res_d = res_q;
        if (in_valid) begin
            res_d.cout = c[N];
            res_d.sum  = s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
            vld_q <= 1'b0;
        end else begin
            res_q <= res_d;
            vld_q <= in_valid;
        end
    end

    assign sum       = res_q.sum;
    assign cout      = res_q.cout;
    assign out_valid = vld_q;

endmodule : param_full_adder

// File: tb/tb_param_full_adder.sv
module tb_param_full_adder;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // N=16 DUT for directed vectors
    logic [15:0] a, b, sum;
    logic        cin, in_valid, cout, out_valid;

    param_full_adder #(.N(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin), .in_valid(in_valid),
        .sum(sum), .cout(cout), .out_valid(out_valid)
    );

    // Sweep DUTs N=1, 8, 64 share one valid strobe
    logic        sv;
    logic [0:0]  a1, b1, s1;
    logic        c1, co1, v1;
    logic [7:0]  a8, b8, s8;
    logic        c8, co8, v8;
    logic [63:0] a64, b64, s64;
    logic        c64, co64, v64;

    param_full_adder #(.N(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .cin(c1), .in_valid(sv),
        .sum(s1), .cout(co1), .out_valid(v1)
    );
    param_full_adder #(.N(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .cin(c8), .in_valid(sv),
        .sum(s8), .cout(co8), .out_valid(v8)
    );
    param_full_adder #(.N(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .a(a64), .b(b64), .cin(c64), .in_valid(sv),
        .sum(s64), .cout(co64), .out_valid(v64)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] a, b;
        logic        cin, vld;
        logic [15:0] es;
        logic        ec, ev;
    } vec_t;

    vec_t tbl[$];

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0]  m1;
        logic [8:0]  m8;
        logic [64:0] m64;
        logic [64:0] r1, r8, r64;

        // Directed table, expectations from hand arithmetic
        tbl.push_back('{16'd1,  16'd2,  1'b0, 1'b1, 16'd3,  1'b0, 1'b1});
        tbl.push_back('{16'd5,  16'd6,  1'b0, 1'b1, 16'd11, 1'b0, 1'b1});
        tbl.push_back('{16'd11, 16'd12, 1'b1, 1'b1, 16'd24, 1'b0, 1'b1});
        tbl.push_back('{16'($urandom), 16'($urandom), 1'($urandom), 1'b0, 16'd24, 1'b0, 1'b0});
        tbl.push_back('{16'hFFFF, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b1});
        tbl.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b1});
        tbl.push_back('{16'd0,  16'd0,  1'b0, 1'b1, 16'd0,  1'b0, 1'b1});
        for (int i = 0; i < 6; i++)
            tbl.push_back('{16'(6 + i), 16'(7 + i), 1'b1, 1'b1, 16'(14 + 2 * i), 1'b0, 1'b1});

        rst_n = 1'b0; a = '0; b = '0; cin = 1'b0; in_valid = 1'b0;
        sv = 1'b0; a1 = '0; b1 = '0; c1 = 1'b0; a8 = '0; b8 = '0; c8 = 1'b0;
        a64 = '0; b64 = '0; c64 = 1'b0;
        #12;
        check("reset sum",  65'(sum), 65'd0);
        check("reset cout", 65'(cout), 65'd0);
        check("reset vld",  65'(out_valid), 65'd0);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            a = tbl[i].a; b = tbl[i].b; cin = tbl[i].cin; in_valid = tbl[i].vld;
            tick();
            check($sformatf("vec%0d sum", i),  65'(sum), 65'(tbl[i].es));
            check($sformatf("vec%0d cout", i), 65'(cout), 65'(tbl[i].ec));
            check($sformatf("vec%0d vld", i),  65'(out_valid), 65'(tbl[i].ev));
        end

        // Mid-stream asynchronous reset, between edges
        a = 16'd100; b = 16'd200; cin = 1'b0; in_valid = 1'b1;
        tick();
        check("pre-rst sum", 65'(sum), 65'd300);
        #2 rst_n = 1'b0;
        #1;
        check("async rst sum",  65'(sum), 65'd0);
        check("async rst cout", 65'(cout), 65'd0);
        check("async rst vld",  65'(out_valid), 65'd0);
        // Edge while held in reset with valid input produces nothing
        tick();
        check("in-rst sum", 65'(sum), 65'd0);
        check("in-rst vld", 65'(out_valid), 65'd0);
        rst_n = 1'b1;
        a = 16'd2; b = 16'd3; cin = 1'b0; in_valid = 1'b1;
        tick();
        check("post-rst sum",  65'(sum), 65'd5);
        check("post-rst cout", 65'(cout), 65'd0);
        check("post-rst vld",  65'(out_valid), 65'd1);
        in_valid = 1'b0;
        tick();
        check("post-rst idle vld", 65'(out_valid), 65'd0);
        check("post-rst hold sum", 65'(sum), 65'd5);

        // Random sweep on N=1/8/64 against plain-arithmetic model
        r1 = '0; r8 = '0; r64 = '0;
        for (int k = 0; k < 1000; k++) begin
            sv = ($urandom_range(0, 3) != 0);
            a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom);
            a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
            a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom}; c64 = 1'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                a8 = 8'hFF; a64 = '1;
                if ($urandom_range(0, 1) == 1) begin b8 = 8'hFF; b64 = '1; end
            end
            m1  = 2'(a1) + 2'(b1) + 2'(c1);
            m8  = 9'(a8) + 9'(b8) + 9'(c8);
            m64 = 65'(a64) + 65'(b64) + 65'(c64);
            if (sv) begin r1 = 65'(m1); r8 = 65'(m8); r64 = m64; end
            tick();
            check("n1 res",  65'({co1, s1}), r1);
            check("n8 res",  65'({co8, s8}), r8);
            check("n64 res", {co64, s64}, r64);
            check("n1 vld",  65'(v1),  65'(sv));
            check("n64 vld", 65'(v64), 65'(sv));
        end
        sv = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_param_full_adder
